zigbee_tx_frame_ctrl: RTL and testbench

//  Transmit-side frame sequencer sitting between the CPU and the EI FIFO (inFIFO) feeding msk_modulator.
//  On a start command it builds one IEEE 802.15.4 PPDU: preamble bytes, SFD, PHR (length), then payload bytes.

---
 rtl/zigbee_pkg.sv | 18 +
 rtl/zigbee_tx_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_zigbee_tx_frame_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zigbee_pkg.sv
// Shared types and constants for the 802.15.4 transmit path.
// Frame state encoding plus fixed PPDU header byte values.
package zigbee_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PHR,
        PAYLOAD,
        DONE
    } tx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h00;
    localparam logic [7:0] SFD_BYTE      = 8'hA7;
    localparam int         PHR_LEN_W     = 7;

endpackage

// File: rtl/zigbee_tx_frame_ctrl.sv
// Transmit frame sequencer: preamble, SFD, PHR, then CPU payload,
// written byte by byte into the modulator FIFO, honouring FIFO full.
module zigbee_tx_frame_ctrl
    import zigbee_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 4,
    parameter int MAX_LENGTH     = 127,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                  inClock,
    input  logic                  inReset,
    input  logic                  inStart,
    input  logic [PHR_LEN_W-1:0]  inLength,
    input  logic                  inAbort,
    input  logic [DATA_WIDTH-1:0] inPayloadData,
    input  logic                  inPayloadValid,
    output logic                  outPayloadReady,
    input  logic                  inFifoFull,
    output logic                  outFifoWrite,
    output logic [DATA_WIDTH-1:0] outFifoData,
    output logic                  outBusy,
    output logic                  outDone,
    output logic                  outError
);

    localparam int PRE_W = $clog2(PREAMBLE_BYTES + 1);

    tx_state_t            state_q, state_d;
    logic [PHR_LEN_W-1:0] len_q, len_d;
    logic [PHR_LEN_W-1:0] byte_q, byte_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic                 error_q, error_d;

    logic emit;
    logic abort_act;
    logic len_ok;

    assign abort_act = inAbort && (state_q != IDLE);
    assign len_ok    = (inLength != '0) && (32'(inLength) <= MAX_LENGTH);
    assign outError  = error_q;
    assign outBusy   = (state_q != IDLE);
    assign outDone   = (state_q == DONE) && !inAbort;

    // State, counter and error-pulse registers
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            state_q <= IDLE;
            len_q   <= '0;
            byte_q  <= '0;
            pre_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            byte_q  <= byte_d;
            pre_q   <= pre_d;
            error_q <= error_d;
        end
    end

    // Next-state, FIFO write gating and byte mux
    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        byte_d          = byte_q;
        pre_d           = pre_q;
        error_d         = 1'b0;
        emit            = 1'b0;
        outFifoData     = '0;
        outPayloadReady = 1'b0;
        outFifoWrite    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (inStart && !inAbort) begin
                    if (len_ok) begin
                        state_d = PREAMBLE;
                        len_d   = inLength;
                        byte_d  = '0;
                        pre_d   = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                emit        = 1'b1;
                outFifoData = DATA_WIDTH'(PREAMBLE_BYTE);
            end
            SFD: begin
                emit        = 1'b1;
                outFifoData = DATA_WIDTH'(SFD_BYTE);
            end
            PHR: begin
                emit        = 1'b1;
                outFifoData = DATA_WIDTH'(len_q);
            end
            PAYLOAD: begin
                emit            = inPayloadValid;
                outFifoData     = inPayloadData;
                outPayloadReady = !inFifoFull && !inAbort;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        outFifoWrite = emit && !inFifoFull && !abort_act;

        // Progress only on an actual FIFO write
        if (outFifoWrite) begin
            unique case (state_q)
                PREAMBLE: begin
                    if (pre_q == PRE_W'(PREAMBLE_BYTES - 1)) begin
                        state_d = SFD;
                        pre_d   = '0;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                SFD: state_d = PHR;
                PHR: state_d = PAYLOAD;
                PAYLOAD: begin
                    byte_d = byte_q + PHR_LEN_W'(1);
                    if (byte_d == len_q) begin
                        state_d = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        if (abort_act) begin
            state_d = IDLE;
            byte_d  = '0;
            pre_d   = '0;
            error_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_zigbee_tx_frame_ctrl.sv
// Self-checking bench for zigbee_tx_frame_ctrl.
// Expected FIFO stream is built from frame rules and compared per write.
module tb_zigbee_tx_frame_ctrl;

    localparam int PRE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] length;
    logic       abort;
    logic [7:0] pdata;
    logic       pvalid;
    logic       pready;
    logic       full;
    logic       fwrite;
    logic [7:0] fdata;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    zigbee_tx_frame_ctrl #(
        .PREAMBLE_BYTES(PRE),
        .MAX_LENGTH(127),
        .DATA_WIDTH(8)
    ) dut (
        .inClock(clk),
        .inReset(rst_n),
        .inStart(start),
        .inLength(length),
        .inAbort(abort),
        .inPayloadData(pdata),
        .inPayloadValid(pvalid),
        .outPayloadReady(pready),
        .inFifoFull(full),
        .outFifoWrite(fwrite),
        .outFifoData(fdata),
        .outBusy(busy),
        .outDone(done),
        .outError(err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        start  = 1'b0;
        length = '0;
        abort  = 1'b0;
        pdata  = '0;
        pvalid = 1'b0;
        full   = 1'b0;
    endtask

    // Runs one frame; the model is the expected byte stream plus write rules.
    task automatic run_frame(input int len, input int fpct, input int vpct,
                             input int abort_w, input int stall_w,
                             input int stall_n, input bit poke,
                             input bit strict, input bit fixed);
        logic [7:0] exp_q[$];
        logic [7:0] pay[$];
        int  widx = 0;
        int  pidx = 0;
        int  stalls = 0;
        int  total;
        bit  fin = 1'b0;
        bit  aborted = 1'b0;
        for (int i = 0; i < len; i++) begin
            pay.push_back(fixed ? 8'((i + 1) * 8'h11) : 8'($urandom));
        end
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'hA7);
        exp_q.push_back(8'(len));
        foreach (pay[i]) exp_q.push_back(pay[i]);
        total = exp_q.size();

        @(negedge clk);
        idle_inputs();
        start  = 1'b1;
        length = 7'(len);
        @(negedge clk);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            bit f;
            bit v;
            bit a;
            bit ew;
            bit er;
            bit live;
            live = !aborted && (widx < total);
            if (widx == stall_w && stalls < stall_n) begin
                f = 1'b1;
                stalls++;
            end else begin
                f = int'($urandom_range(99)) < fpct;
            end
            v      = int'($urandom_range(99)) < vpct;
            a      = live && (widx == abort_w);
            full   = f;
            pvalid = v;
            pdata  = (pidx < len) ? pay[pidx] : 8'($urandom);
            abort  = a;
            start  = live && poke && ($urandom_range(1) == 1);
            length = 7'($urandom);
            #1;
            if (aborted) begin
                checks++;
                if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_end err=%b busy=%b done=%b want 1 0 0",
                             err, busy, done);
                end
                checks++;
                if (widx !== abort_w) begin
                    errors++;
                    $display("FAIL abort_writes got %0d want %0d", widx, abort_w);
                end
                fin = 1'b1;
            end else if (widx == total) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b1 || fwrite !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse done=%b busy=%b wr=%b want 1 1 0",
                             done, busy, fwrite);
                end
                checks++;
                if (pidx !== len) begin
                    errors++;
                    $display("FAIL payload_taken got %0d want %0d", pidx, len);
                end
                if (strict) begin
                    checks++;
                    if (cyc !== total) begin
                        errors++;
                        $display("FAIL latency done_cycle %0d want %0d", cyc, total);
                    end
                end
                fin = 1'b1;
            end else begin
                ew = !f && !a && (widx < PRE + 2 || v);
                er = (widx >= PRE + 2) && !f && !a;
                checks++;
                if (fwrite !== ew || pready !== er) begin
                    errors++;
                    $display("FAIL write_rule idx=%0d wr=%b rdy=%b want %b %b",
                             widx, fwrite, pready, ew, er);
                end
                if (widx < PRE + 2 || v) begin
                    checks++;
                    if (fdata !== exp_q[widx]) begin
                        errors++;
                        $display("FAIL fifo_data idx=%0d got %h want %h",
                                 widx, fdata, exp_q[widx]);
                    end
                end
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL in_frame busy=%b done=%b err=%b want 1 0 0",
                             busy, done, err);
                end
                if (ew) widx++;
                if (er && v) pidx++;
                aborted = a;
            end
            @(negedge clk);
            idle_inputs();
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout writes %0d of %0d", widx, total);
        end
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL after_frame busy=%b done=%b err=%b want 0 0 0",
                     busy, done, err);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fwrite, pready, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000",
                     {fwrite, pready, busy, done, err});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_frame(3, 0, 100, -1, -1, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_stall_sfd();
        run_frame(3, 0, 100, -1, PRE, 3, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        start  = 1'b1;
        length = 7'd0;
        #1;
        checks++;
        if (fwrite !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_start wr=%b busy=%b want 0 0", fwrite, busy);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || fwrite !== 1'b0) begin
            errors++;
            $display("FAIL zero_len err=%b busy=%b wr=%b want 1 0 0",
                     err, busy, fwrite);
        end
        @(negedge clk);
        start  = 1'b1;
        length = 7'd5;
        abort  = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || fwrite !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_idle busy=%b err=%b wr=%b want 0 0 0",
                     busy, err, fwrite);
        end
    endtask

    task automatic test_abort();
        run_frame(5, 0, 100, PRE + 4, -1, 0, 1'b0, 1'b0, 1'b0);
        run_frame(1, 0, 100, -1, -1, 0, 1'b0, 1'b1, 1'b0);
        run_frame(20, 30, 70, 2, -1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_valid_gaps();
        run_frame(12, 0, 40, -1, -1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_busy();
        run_frame(10, 20, 80, -1, -1, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start  = 1'b1;
        length = 7'd4;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fwrite, pready, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid got %b want 00000",
                     {fwrite, pready, busy, done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(4, 0, 100, -1, -1, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            run_frame(int'($urandom_range(40, 1)), int'($urandom_range(40)),
                      int'($urandom_range(100, 50)), -1, -1, 0, 1'b1,
                      1'b0, 1'b0);
        end
        run_frame(127, 10, 90, -1, -1, 0, 1'b0, 1'b0, 1'b0);
        run_frame(127, 0, 100, -1, -1, 0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_sfd();
        test_zero_len();
        test_abort();
        test_valid_gaps();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
